// File: rtl/gb_pkg.sv
// Shared DMG definitions: IO register offsets, timer overflow states and the
// CPU control enums used across the core.
package gb_pkg;

  localparam logic [1:0] IO_DIV_OFS  = 2'd0;
  localparam logic [1:0] IO_TIMA_OFS = 2'd1;
  localparam logic [1:0] IO_TMA_OFS  = 2'd2;
  localparam logic [1:0] IO_TAC_OFS  = 2'd3;

  typedef enum logic [1:0] {
    TIMA_RUN = 2'd0,
    TIMA_OVF = 2'd1,
    TIMA_RLD = 2'd2
  } tima_state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_ADC = 4'd1,
    ALU_SUB = 4'd2,
    ALU_SBC = 4'd3,
    ALU_AND = 4'd4,
    ALU_XOR = 4'd5,
    ALU_OR  = 4'd6,
    ALU_CP  = 4'd7,
    ALU_INC = 4'd8,
    ALU_DEC = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    COND_NONE = 3'd0,
    COND_NZ   = 3'd1,
    COND_Z    = 3'd2,
    COND_NC   = 3'd3,
    COND_C    = 3'd4
  } cond_e;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_READ  = 2'd1,
    BUS_WRITE = 2'd2
  } bus_op_e;

endpackage

// File: rtl/timer.sv
// DMG timer block: DIV/TIMA/TMA/TAC bus responder, 16-bit system counter and
// TIMA overflow/reload sequencing with the interrupt request pulse.
module timer
  import gb_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  t_cycle,
  input  logic [15:0] mem_addr,
  input  logic        mem_enable,
  input  logic        mem_write,
  input  logic [7:0]  mem_data_in,
  output logic [7:0]  mem_data_out,
  output logic        hit,
  output logic        timer_irq,
  output logic [7:0]  div
);

  logic [15:0] counter_r;
  logic [7:0]  tima_r;
  logic [7:0]  tma_r;
  logic [2:0]  tac_r;
  logic        prev_sel_r;
  tima_state_e state_r;
  logic [1:0]  sub_r;
  logic        irq_r;

  logic [15:0] offset_s;
  logic        hit_s;
  logic        wr_s;
  logic        wr_div_s;
  logic        wr_tima_s;
  logic        wr_tma_s;
  logic        wr_tac_s;
  logic [7:0]  tma_nx_s;
  logic [7:0]  rdata_s;
  logic        mux_bit_s;
  logic        sel_s;
  logic        tick_s;

  // Address decode and write strobes; modular offset keeps the range check wrap-safe
  always_comb begin
    offset_s  = mem_addr - BASE_ADDR;
    hit_s     = mem_enable && (offset_s[15:2] == 14'd0);
    wr_s      = hit_s && mem_write && (t_cycle == 2'd3);
    wr_div_s  = wr_s && (offset_s[1:0] == IO_DIV_OFS);
    wr_tima_s = wr_s && (offset_s[1:0] == IO_TIMA_OFS);
    wr_tma_s  = wr_s && (offset_s[1:0] == IO_TMA_OFS);
    wr_tac_s  = wr_s && (offset_s[1:0] == IO_TAC_OFS);
    tma_nx_s  = wr_tma_s ? mem_data_in : tma_r;
  end

  // Read data mux, open-bus 0xFF when not selected
  always_comb begin
    rdata_s = 8'hFF;
    if (hit_s) begin
      case (offset_s[1:0])
        IO_DIV_OFS:  rdata_s = counter_r[15:8];
        IO_TIMA_OFS: rdata_s = tima_r;
        IO_TMA_OFS:  rdata_s = tma_r;
        IO_TAC_OFS:  rdata_s = {5'b11111, tac_r};
        default:     rdata_s = 8'hFF;
      endcase
    end else begin
      rdata_s = 8'hFF;
    end
  end

  // Tick source select; a falling sel after a DIV/TAC write still ticks (hardware glitch)
  always_comb begin
    case (tac_r[1:0])
      2'b00:   mux_bit_s = counter_r[9];
      2'b01:   mux_bit_s = counter_r[3];
      2'b10:   mux_bit_s = counter_r[5];
      2'b11:   mux_bit_s = counter_r[7];
      default: mux_bit_s = 1'b0;
    endcase
    sel_s  = mux_bit_s & tac_r[2];
    tick_s = prev_sel_r & ~sel_s;
  end

  // System counter, cleared by any DIV write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter_r <= 16'h0000;
    end else if (wr_div_s) begin
      counter_r <= 16'h0000;
    end else begin
      counter_r <= counter_r + 16'h0001;
    end
  end

  // TAC/TMA registers and the sel edge-detect history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tac_r      <= 3'b000;
      tma_r      <= 8'h00;
      prev_sel_r <= 1'b0;
    end else begin
      tma_r      <= tma_nx_s;
      prev_sel_r <= sel_s;
      if (wr_tac_s) begin
        tac_r <= mem_data_in[2:0];
      end
    end
  end

  // TIMA counting with the overflow -> reload -> run sequence
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tima_r  <= 8'h00;
      state_r <= TIMA_RUN;
      sub_r   <= 2'd0;
      irq_r   <= 1'b0;
    end else begin
      irq_r <= 1'b0;
      case (state_r)
        TIMA_RUN: begin
          sub_r <= 2'd0;
          if (wr_tima_s) begin
            tima_r <= mem_data_in;
          end else if (tick_s) begin
            if (tima_r == 8'hFF) begin
              tima_r  <= 8'h00;
              state_r <= TIMA_OVF;
            end else begin
              tima_r <= tima_r + 8'h01;
            end
          end
        end
        TIMA_OVF: begin
          if (wr_tima_s) begin
            tima_r  <= mem_data_in;
            state_r <= TIMA_RUN;
            sub_r   <= 2'd0;
          end else if (sub_r == 2'd3) begin
            tima_r  <= tma_nx_s;
            irq_r   <= 1'b1;
            state_r <= TIMA_RLD;
            sub_r   <= 2'd0;
          end else begin
            sub_r <= sub_r + 2'd1;
          end
        end
        TIMA_RLD: begin
          if (wr_tma_s) begin
            tima_r <= mem_data_in;
          end
          if (sub_r == 2'd3) begin
            state_r <= TIMA_RUN;
            sub_r   <= 2'd0;
          end else begin
            sub_r <= sub_r + 2'd1;
          end
        end
        default: begin
          state_r <= TIMA_RUN;
          sub_r   <= 2'd0;
        end
      endcase
    end
  end

  assign mem_data_out = rdata_s;
  assign hit          = hit_s;
  assign timer_irq    = irq_r;
  assign div          = counter_r[15:8];

endmodule

// File: tb/tb_timer.sv
// Directed bench for the DMG timer: free run, overflow/reload, cancel, reload
// window, DIV glitch, decode and asynchronous reset during overflow.
module tb_timer;

  logic        clk;
  logic        reset;
  logic [1:0]  t_cycle;
  logic [15:0] mem_addr;
  logic        mem_enable;
  logic        mem_write;
  logic [7:0]  mem_data_in;
  logic [7:0]  mem_data_out;
  logic        hit;
  logic        timer_irq;
  logic [7:0]  div;

  int total;
  int bad;

  timer #(.BASE_ADDR(16'hFF04)) dut (
    .clk          (clk),
    .reset        (reset),
    .t_cycle      (t_cycle),
    .mem_addr     (mem_addr),
    .mem_enable   (mem_enable),
    .mem_write    (mem_write),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .hit          (hit),
    .timer_irq    (timer_irq),
    .div          (div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] addr, output logic [7:0] d, output logic h);
    mem_addr   = addr;
    mem_enable = 1'b1;
    mem_write  = 1'b0;
    #1;
    d = mem_data_out;
    h = hit;
    mem_enable = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data, input logic [1:0] tc);
    mem_addr    = addr;
    mem_data_in = data;
    mem_enable  = 1'b1;
    mem_write   = 1'b1;
    t_cycle     = tc;
    step();
    mem_enable  = 1'b0;
    mem_write   = 1'b0;
    t_cycle     = 2'd0;
  endtask

  logic [7:0] d;
  logic       h;

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    t_cycle = 2'd0;
    mem_addr = 16'h0000;
    mem_enable = 1'b0;
    mem_write = 1'b0;
    mem_data_in = 8'h00;

    // reset state
    #2;
    chk("rst_div", {8'h00, div}, 16'h0000);
    chk("rst_irq", {15'd0, timer_irq}, 16'h0000);
    rd(16'hFF05, d, h); chk("rst_tima", {8'h00, d}, 16'h0000);
    rd(16'hFF07, d, h); chk("rst_tac", {8'h00, d}, 16'h00F8);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // free run: 256 clks -> DIV = 01
    repeat (256) step();
    chk("run_div_out", {8'h00, div}, 16'h0001);
    rd(16'hFF04, d, h); chk("run_div_rd", {8'h00, d}, 16'h0001);
    chk("run_div_hit", {15'd0, h}, 16'h0001);
    rd(16'hFF07, d, h); chk("run_tac_rd", {8'h00, d}, 16'h00F8);

    // setup: counter ends at 1 with TAC=101
    wr(16'hFF05, 8'hFE, 2'd3);
    wr(16'hFF06, 8'h42, 2'd3);
    wr(16'hFF04, 8'h99, 2'd3);
    wr(16'hFF07, 8'h05, 2'd3);
    rd(16'hFF07, d, h); chk("tac_rd", {8'h00, d}, 16'h00FD);
    repeat (15) step();
    rd(16'hFF05, d, h); chk("tima_fe_c16", {8'h00, d}, 16'h00FE);
    step();
    rd(16'hFF05, d, h); chk("tima_ff_c17", {8'h00, d}, 16'h00FF);
    repeat (15) step();
    rd(16'hFF05, d, h); chk("tima_ff_c32", {8'h00, d}, 16'h00FF);
    for (int i = 0; i < 4; i++) begin
      step();
      rd(16'hFF05, d, h); chk("ovf_tima_00", {8'h00, d}, 16'h0000);
      chk("ovf_irq_lo", {15'd0, timer_irq}, 16'h0000);
    end
    step();
    rd(16'hFF05, d, h); chk("reload_tima", {8'h00, d}, 16'h0042);
    chk("reload_irq", {15'd0, timer_irq}, 16'h0001);
    step();
    chk("irq_one_clk", {15'd0, timer_irq}, 16'h0000);

    // reload window: TIMA write ignored, TMA write mirrors into TIMA
    wr(16'hFF05, 8'h77, 2'd3);
    rd(16'hFF05, d, h); chk("rld_tima_ign", {8'h00, d}, 16'h0042);
    wr(16'hFF06, 8'h55, 2'd3);
    rd(16'hFF05, d, h); chk("rld_tma_tima", {8'h00, d}, 16'h0055);
    rd(16'hFF06, d, h); chk("rld_tma", {8'h00, d}, 16'h0055);
    repeat (8) step();
    rd(16'hFF05, d, h); chk("run_c48", {8'h00, d}, 16'h0055);
    step();
    rd(16'hFF05, d, h); chk("run_c49_inc", {8'h00, d}, 16'h0056);

    // overflow cancel by TIMA write
    wr(16'hFF05, 8'hFF, 2'd3);
    repeat (14) step();
    rd(16'hFF05, d, h); chk("cancel_ff", {8'h00, d}, 16'h00FF);
    step();
    step();
    rd(16'hFF05, d, h); chk("cancel_ovf00", {8'h00, d}, 16'h0000);
    wr(16'hFF05, 8'h10, 2'd3);
    rd(16'hFF05, d, h); chk("cancel_tima", {8'h00, d}, 16'h0010);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("cancel_no_irq", {15'd0, timer_irq}, 16'h0000);
      rd(16'hFF05, d, h); chk("cancel_no_rld", {8'h00, d}, 16'h0010);
    end

    // TIMA write and tick on the same clk: write wins
    repeat (8) step();
    wr(16'hFF05, 8'h20, 2'd3);
    rd(16'hFF05, d, h); chk("write_wins", {8'h00, d}, 16'h0020);

    // DIV-write glitch with counter[3] = 1
    repeat (7) step();
    wr(16'hFF04, 8'h00, 2'd3);
    chk("glitch_div", {8'h00, div}, 16'h0000);
    rd(16'hFF05, d, h); chk("glitch_pre", {8'h00, d}, 16'h0020);
    step();
    rd(16'hFF05, d, h); chk("glitch_inc", {8'h00, d}, 16'h0021);

    // decode
    rd(16'hFF03, d, h); chk("dec_ff03_hit", {15'd0, h}, 16'h0000);
    chk("dec_ff03_data", {8'h00, d}, 16'h00FF);
    rd(16'hFF08, d, h); chk("dec_ff08_hit", {15'd0, h}, 16'h0000);
    chk("dec_ff08_data", {8'h00, d}, 16'h00FF);

    // write outside t_cycle 3 does not commit
    wr(16'hFF06, 8'h99, 2'd1);
    rd(16'hFF06, d, h); chk("tc_nocommit", {8'h00, d}, 16'h0055);

    // async reset mid-overflow
    wr(16'hFF05, 8'hFF, 2'd3);
    repeat (14) step();
    step();
    rd(16'hFF05, d, h); chk("pre_rst_ovf", {8'h00, d}, 16'h0000);
    step();
    reset = 1'b0;
    #1;
    chk("arst_div", {8'h00, div}, 16'h0000);
    chk("arst_irq", {15'd0, timer_irq}, 16'h0000);
    rd(16'hFF06, d, h); chk("arst_tma", {8'h00, d}, 16'h0000);
    rd(16'hFF07, d, h); chk("arst_tac", {8'h00, d}, 16'h00F8);
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_irq", {15'd0, timer_irq}, 16'h0000);
    end
    rd(16'hFF05, d, h); chk("post_rst_tima", {8'h00, d}, 16'h0000);
    chk("post_rst_div", {8'h00, div}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
